// File: rtl/clock_freq_meter.sv
// Frequency meter: counts synchronized rising edges of SIG_IN over a gate of
// CLK_FREQ system-clock cycles (one second) and reports the count in Hz.
module clock_freq_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             RESET_n,
  input  logic             CLK,
  input  logic [31:0]      CLK_FREQ,
  input  logic             SIG_IN,
  input  logic             START,
  input  logic             CONT,
  output logic [CNT_W-1:0] FREQ_OUT,
  output logic             FREQ_VALID,
  output logic             BUSY,
  output logic             OVERFLOW,
  output logic             CFG_ERR
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev;
  logic                   edge_pulse;
  logic [31:0]            gate_len;
  logic [31:0]            gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       edge_cnt_nxt;
  logic                   ovf_flag;
  logic                   ovf_nxt;

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign edge_pulse = sync_out & ~prev;

  // Reset to 0 so a signal already high at reset release counts as one edge.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_IN};
      prev   <= sync_out;
    end
  end

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_flag;
    if (edge_pulse) begin
      if (&edge_cnt) ovf_nxt = 1'b1;
      else           edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  // Results are loaded on the last GATE edge so they are visible during DONE.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      gate_len   <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      FREQ_OUT   <= '0;
      FREQ_VALID <= 1'b0;
      BUSY       <= 1'b0;
      OVERFLOW   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      FREQ_VALID <= 1'b0;
      CFG_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (START || CONT) begin
            gate_len <= CLK_FREQ;
            if (CLK_FREQ == 32'd0) begin
              CFG_ERR <= 1'b1;
            end else begin
              state <= ARM;
              BUSY  <= 1'b1;
            end
          end
        end
        ARM: begin
          edge_cnt <= '0;
          gate_cnt <= '0;
          ovf_flag <= 1'b0;
          state    <= GATE;
        end
        GATE: begin
          gate_cnt <= gate_cnt + 32'd1;
          edge_cnt <= edge_cnt_nxt;
          ovf_flag <= ovf_nxt;
          if (gate_cnt == gate_len - 32'd1) begin
            FREQ_OUT   <= edge_cnt_nxt;
            OVERFLOW   <= ovf_nxt;
            FREQ_VALID <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (CONT) begin
            gate_len <= CLK_FREQ;
            if (CLK_FREQ == 32'd0) begin
              CFG_ERR <= 1'b1;
              BUSY    <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= ARM;
            end
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: a 32-bit and a 4-bit instance share the
// same stimulus so saturation can be checked alongside the normal count.
module tb_clock_freq_meter;

  logic        RESET_n;
  logic        CLK;
  logic [31:0] CLK_FREQ;
  logic        SIG_IN;
  logic        START;
  logic        CONT;
  logic [31:0] freq_out;
  logic        freq_valid;
  logic        busy;
  logic        overflow;
  logic        cfg_err;
  logic [3:0]  small_freq_out;
  logic        small_freq_valid;
  logic        small_busy;
  logic        small_overflow;
  logic        small_cfg_err;

  int tests_run = 0;
  int tests_failed = 0;
  int sig_period = 10;
  int sig_phase = 0;

  clock_freq_meter #(.CNT_W(32), .SYNC_STAGES(2)) dut (
    .RESET_n(RESET_n), .CLK(CLK), .CLK_FREQ(CLK_FREQ), .SIG_IN(SIG_IN),
    .START(START), .CONT(CONT), .FREQ_OUT(freq_out), .FREQ_VALID(freq_valid),
    .BUSY(busy), .OVERFLOW(overflow), .CFG_ERR(cfg_err)
  );

  clock_freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_small (
    .RESET_n(RESET_n), .CLK(CLK), .CLK_FREQ(CLK_FREQ), .SIG_IN(SIG_IN),
    .START(START), .CONT(CONT), .FREQ_OUT(small_freq_out),
    .FREQ_VALID(small_freq_valid), .BUSY(small_busy),
    .OVERFLOW(small_overflow), .CFG_ERR(small_cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Free-running square wave, rising once per sig_period cycles.
  always @(negedge CLK) begin
    if (sig_period < 2) begin
      sig_phase = 0;
      SIG_IN = 1'b0;
    end else begin
      sig_phase = (sig_phase + 1 >= sig_period) ? 0 : sig_phase + 1;
      SIG_IN = (sig_phase < sig_period / 2);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] freq);
    @(negedge CLK);
    CLK_FREQ = freq;
    START = 1'b1;
  endtask

  task automatic waitValid(input int limit, output int cycles);
    int i;
    cycles = -1;
    i = 0;
    while (cycles < 0 && i < limit) begin
      @(negedge CLK);
      START = 1'b0;
      i++;
      if (freq_valid) cycles = i;
    end
  endtask

  task automatic idleCycles(input int n, output int valids);
    valids = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (freq_valid) valids++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int errs;
    int busy_seen;
    int valid_seen;

    RESET_n = 1'b0;
    CLK_FREQ = 32'd100;
    START = 1'b0;
    CONT = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_freq_out", freq_out, 32'd0);
    checkOutput("reset_valid", 32'(freq_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_cfg_err", 32'(cfg_err), 32'd0);
    RESET_n = 1'b1;
    idleCycles(30, cnt);
    checkOutput("idle_no_valid", 32'(cnt), 32'd0);

    // One-shot, period 10 over a 100-cycle gate.
    applyStimulus(32'd100);
    @(negedge CLK);
    START = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitValid(300, lat);
    checkOutput("oneshot_latency", 32'(lat + 1), 32'd102);
    checkOutput("oneshot_freq", freq_out, 32'd10);
    checkOutput("oneshot_ovf", 32'(overflow), 32'd0);
    checkOutput("oneshot_busy_done", 32'(busy), 32'd1);
    @(negedge CLK);
    checkOutput("oneshot_valid_pulse", 32'(freq_valid), 32'd0);
    checkOutput("oneshot_busy_low", 32'(busy), 32'd0);

    // Zero gate length is rejected with a single error pulse.
    applyStimulus(32'd0);
    errs = 0; busy_seen = 0; valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (cfg_err) errs++;
      if (busy) busy_seen++;
      if (freq_valid) valid_seen++;
    end
    checkOutput("cfg_err_pulses", 32'(errs), 32'd1);
    checkOutput("cfg_err_busy", 32'(busy_seen), 32'd0);
    checkOutput("cfg_err_valid", 32'(valid_seen), 32'd0);
    checkOutput("cfg_err_freq_hold", freq_out, 32'd10);

    // Saturation in the 4-bit instance, normal count in the 32-bit one.
    sig_period = 4;
    idleCycles(20, cnt);
    applyStimulus(32'd100);
    waitValid(300, lat);
    checkOutput("sat_latency", 32'(lat), 32'd102);
    checkOutput("sat_freq_wide", freq_out, 32'd25);
    checkOutput("sat_ovf_wide", 32'(overflow), 32'd0);
    checkOutput("sat_freq_small", 32'(small_freq_out), 32'd15);
    checkOutput("sat_ovf_small", 32'(small_overflow), 32'd1);
    sig_period = 10;
    idleCycles(20, cnt);
    applyStimulus(32'd100);
    waitValid(300, lat);
    checkOutput("unsat_freq_small", 32'(small_freq_out), 32'd10);
    checkOutput("unsat_ovf_small", 32'(small_overflow), 32'd0);

    // CLK_FREQ changed mid-gate does not affect the running measurement.
    applyStimulus(32'd100);
    idleCycles(30, cnt);
    CLK_FREQ = 32'd50;
    waitValid(300, lat);
    checkOutput("freqchg_latency", 32'(lat + 30), 32'd102);
    checkOutput("freqchg_freq", freq_out, 32'd10);
    idleCycles(3, cnt);
    applyStimulus(32'd50);
    waitValid(300, lat);
    checkOutput("freq50_latency", 32'(lat), 32'd52);
    checkOutput("freq50_freq", freq_out, 32'd5);

    // Continuous mode: period 20, then period 5, then CONT dropped mid-gate.
    CLK_FREQ = 32'd100;
    sig_period = 20;
    idleCycles(40, cnt);
    @(negedge CLK);
    CONT = 1'b1;
    waitValid(300, lat);
    checkOutput("cont_first_latency", 32'(lat), 32'd102);
    checkOutput("cont_first_freq", freq_out, 32'd5);
    waitValid(300, lat);
    checkOutput("cont_period", 32'(lat), 32'd102);
    checkOutput("cont_second_freq", freq_out, 32'd5);
    sig_period = 5;
    waitValid(300, lat);
    checkOutput("cont_trans_period", 32'(lat), 32'd102);
    waitValid(300, lat);
    checkOutput("cont_settled_period", 32'(lat), 32'd102);
    checkOutput("cont_settled_freq", freq_out, 32'd20);
    idleCycles(30, cnt);
    CONT = 1'b0;
    waitValid(300, lat);
    checkOutput("cont_drop_latency", 32'(lat + 30), 32'd102);
    checkOutput("cont_drop_freq", freq_out, 32'd20);
    @(negedge CLK);
    checkOutput("cont_drop_busy", 32'(busy), 32'd0);
    idleCycles(250, cnt);
    checkOutput("cont_drop_no_more", 32'(cnt), 32'd0);

    // Asynchronous reset mid-gate discards the measurement.
    sig_period = 10;
    idleCycles(20, cnt);
    applyStimulus(32'd100);
    idleCycles(40, cnt);
    #2 RESET_n = 1'b0;
    #1;
    checkOutput("async_rst_freq", freq_out, 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_valid", 32'(freq_valid), 32'd0);
    idleCycles(3, cnt);
    RESET_n = 1'b1;
    idleCycles(150, cnt);
    checkOutput("rst_no_valid", 32'(cnt), 32'd0);
    checkOutput("rst_idle_busy", 32'(busy), 32'd0);
    applyStimulus(32'd100);
    waitValid(300, lat);
    checkOutput("rst_recover_latency", 32'(lat), 32'd102);
    checkOutput("rst_recover_freq", freq_out, 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
